// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard detection and operand forwarding.
// Keeps shadow copies {wreg, m2reg, rd} of the execute, memory and write-back
// stages. From those and the decode operands it produces the forwarding
// selects, the load-use / busy stall, the decode/execute bubble, and a
// saturating count of stalled cycles.
module hazard_unit #(
   parameter int CNTW = 16
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [4:0]      drs,
   input  logic [4:0]      drt,
   input  logic            dusers,
   input  logic            duset,
   input  logic            dwreg,
   input  logic            dm2reg,
   input  logic [4:0]      drd,
   input  logic            flush,
   input  logic            ebusy,
   output logic            stall,
   output logic            bubble,
   output logic [1:0]      fwda,
   output logic [1:0]      fwdb,
   output logic [CNTW-1:0] stallcnt
);

   typedef struct packed {
      logic       wreg;
      logic       m2reg;
      logic [4:0] rd;
   } slot_t;

   localparam logic [CNTW-1:0] CNT_MAX = '1;

   slot_t           e_q, e_d;
   slot_t           m_q, m_d;
   slot_t           w_q, w_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            load_use;

   // A slot supplies a source when it writes that register; r0 is hard-wired zero.
   function automatic logic slot_match(input slot_t s, input logic [4:0] src);
      return s.wreg && (s.rd == src) && (s.rd != 5'd0);
   endfunction

   // Youngest producer wins: E before M before W, regfile otherwise.
   function automatic logic [1:0] fwd_sel(input slot_t e, input slot_t m,
                                          input slot_t w, input logic [4:0] src,
                                          input logic used);
      if (!used)                 return 2'd0;
      else if (slot_match(e, src)) return 2'd1;
      else if (slot_match(m, src)) return 2'd2;
      else if (slot_match(w, src)) return 2'd3;
      else                       return 2'd0;
   endfunction

   // Hazard detection and forwarding outputs, gated so everything reads 0 in reset.
   always_comb begin
      load_use = e_q.m2reg &&
                 ((dusers && slot_match(e_q, drs)) || (duset && slot_match(e_q, drt)));
      // A redirect kills the decode instruction, so it never needs to wait.
      stall    = reset && (load_use || ebusy) && !flush;
      // While execute holds, the decode/execute register is frozen and takes no bubble.
      bubble   = reset && (load_use || flush) && !ebusy;
      fwda     = reset ? fwd_sel(e_q, m_q, w_q, drs, dusers) : 2'd0;
      fwdb     = reset ? fwd_sel(e_q, m_q, w_q, drt, duset)  : 2'd0;
      stallcnt = cnt_q;
   end

   // Next-state of the shadow slots and the stall counter.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      e_d   = e_q;
      m_d   = m_q;
      w_d   = m_q;
      cnt_d = cnt_q;
      if (!ebusy) begin
         e_d = bubble ? '0 : slot_t'{wreg: dwreg, m2reg: dm2reg, rd: drd};
         m_d = e_q;
      end else begin
         // Execute holds its instruction; memory receives an empty slot.
         m_d = '0;
      end
      if (stall && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNTW'(1);
      end
   end

   // State registers, cleared immediately by the asynchronous reset.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: non-blocking assignments so all flops sample pre-edge values together.
      if (!reset) begin
         e_q   <= '0;
         m_q   <= '0;
         w_q   <= '0;
         cnt_q <= '0;
      end else begin
         e_q   <= e_d;
         m_q   <= m_d;
         w_q   <= w_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and random stimulus for hazard_unit. A driver
// pushes the expected response of a behavioural pipeline model into a
// scoreboard queue; a monitor pops and compares on the falling edge.
module tb_hazard_unit;

   typedef struct {
      bit       rst;
      bit [4:0] drs, drt;
      bit       dusers, duset, dwreg, dm2reg;
      bit [4:0] drd;
      bit       flush, ebusy;
   } in_t;

   typedef struct {
      bit       stall, bubble;
      bit [1:0] fwda, fwdb;
      int       cnt16, cnt2;
   } exp_t;

   typedef struct {
      bit       wreg, m2reg;
      bit [4:0] rd;
   } stage_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [4:0]  drs = '0, drt = '0, drd = '0;
   logic        dusers = 1'b0, duset = 1'b0, dwreg = 1'b0, dm2reg = 1'b0;
   logic        flush = 1'b0, ebusy = 1'b0;
   logic        stall, bubble, stall2, bubble2;
   logic [1:0]  fwda, fwdb, fwda2, fwdb2;
   logic [15:0] stallcnt;
   logic [1:0]  stallcnt2;

   int checks = 0;
   int errors = 0;

   exp_t   sb[$];
   stage_t pipe[3];   // index 0 = execute, 1 = memory, 2 = write-back
   int     cnt16 = 0;
   int     cnt2  = 0;

   always #5 clock = ~clock;

   hazard_unit #(.CNTW(16)) dut (
      .clock(clock), .reset(reset), .drs(drs), .drt(drt), .dusers(dusers),
      .duset(duset), .dwreg(dwreg), .dm2reg(dm2reg), .drd(drd), .flush(flush),
      .ebusy(ebusy), .stall(stall), .bubble(bubble), .fwda(fwda), .fwdb(fwdb),
      .stallcnt(stallcnt)
   );

   hazard_unit #(.CNTW(2)) dut2 (
      .clock(clock), .reset(reset), .drs(drs), .drt(drt), .dusers(dusers),
      .duset(duset), .dwreg(dwreg), .dm2reg(dm2reg), .drd(drd), .flush(flush),
      .ebusy(ebusy), .stall(stall2), .bubble(bubble2), .fwda(fwda2), .fwdb(fwdb2),
      .stallcnt(stallcnt2)
   );

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic in_t mk(input bit [4:0] rs, input bit urs, input bit [4:0] rt,
                              input bit urt, input bit wr, input bit ld,
                              input bit [4:0] rd, input bit fl, input bit eb);
      in_t x;
      x.rst = 1'b1; x.drs = rs; x.dusers = urs; x.drt = rt; x.duset = urt;
      x.dwreg = wr; x.dm2reg = ld; x.drd = rd; x.flush = fl; x.ebusy = eb;
      return x;
   endfunction

   function automatic in_t rand_in();
      in_t x;
      x.rst    = ($urandom_range(0, 59) != 0);
      x.drs    = 5'($urandom_range(0, 7));
      x.drt    = 5'($urandom_range(0, 7));
      x.dusers = 1'($urandom_range(0, 3) != 0);
      x.duset  = 1'($urandom_range(0, 1));
      x.dwreg  = 1'($urandom_range(0, 3) != 0);
      x.dm2reg = ($urandom_range(0, 2) == 0);
      x.drd    = 5'($urandom_range(0, 7));
      x.flush  = ($urandom_range(0, 7) == 0);
      x.ebusy  = ($urandom_range(0, 5) == 0);
      return x;
   endfunction

   // Youngest stage that will write the register supplies it; r0 never forwards.
   function automatic bit [1:0] model_fwd(input bit [4:0] r, input bit used);
      if (!used || r == 5'd0) return 2'd0;
      for (int i = 0; i < 3; i++)
         if (pipe[i].wreg && pipe[i].rd == r) return 2'(i + 1);
      return 2'd0;
   endfunction

   // Apply one cycle of inputs, record the expected response, advance the model.
   task automatic drive(input in_t x);
      exp_t   e;
      bit     lu;
      stage_t nd;
      @(posedge clock);
      #1;
      reset = x.rst; drs = x.drs; drt = x.drt; dusers = x.dusers; duset = x.duset;
      dwreg = x.dwreg; dm2reg = x.dm2reg; drd = x.drd; flush = x.flush; ebusy = x.ebusy;
      if (!x.rst) begin
         foreach (pipe[i]) pipe[i] = '{0, 0, 5'd0};
         cnt16 = 0; cnt2 = 0;
         e = '{0, 0, 2'd0, 2'd0, 0, 0};
         sb.push_back(e);
         #1;
         check("reset_immediate_stallcnt", int'(stallcnt), 0);
         check("reset_immediate_stall", int'(stall), 0);
         check("reset_immediate_bubble", int'(bubble), 0);
         check("reset_immediate_fwd", int'({fwda, fwdb}), 0);
         return;
      end
      lu = pipe[0].m2reg && (model_fwd(x.drs, x.dusers) == 2'd1 ||
                             model_fwd(x.drt, x.duset) == 2'd1);
      e.stall  = (lu || x.ebusy) && !x.flush;
      e.bubble = (lu || x.flush) && !x.ebusy;
      e.fwda   = model_fwd(x.drs, x.dusers);
      e.fwdb   = model_fwd(x.drt, x.duset);
      e.cnt16  = cnt16;
      e.cnt2   = cnt2;
      sb.push_back(e);
      if (e.stall) begin
         if (cnt16 < 65535) cnt16++;
         if (cnt2 < 3) cnt2++;
      end
      nd = e.bubble ? '{0, 0, 5'd0} : '{x.dwreg, x.dm2reg, x.drd};
      pipe[2] = pipe[1];
      if (!x.ebusy) begin
         pipe[1] = pipe[0];
         pipe[0] = nd;
      end else begin
         pipe[1] = '{0, 0, 5'd0};
      end
   endtask

   // Monitor: compares whatever response the DUT presents this cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("stall", int'(stall), int'(e.stall));
            check("bubble", int'(bubble), int'(e.bubble));
            check("fwda", int'(fwda), int'(e.fwda));
            check("fwdb", int'(fwdb), int'(e.fwdb));
            check("stallcnt", int'(stallcnt), e.cnt16);
            check("stallcnt_cntw2", int'(stallcnt2), e.cnt2);
         end
      end
   end

   initial begin
      in_t idle, rst0;
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst0 = idle; rst0.rst = 1'b0;
      drive(rst0);
      drive(rst0);
      // add r3 in E, then E-forward, then M-forward
      drive(mk(0, 0, 0, 0, 1, 0, 5'd3, 0, 0));
      drive(mk(5'd3, 1, 0, 0, 0, 0, 5'd0, 0, 0));
      drive(mk(5'd3, 1, 0, 0, 0, 0, 5'd0, 0, 0));
      // load r5, dependent rt: one stall, then forward from M
      drive(mk(0, 0, 0, 0, 1, 1, 5'd5, 0, 0));
      drive(mk(0, 0, 5'd5, 1, 1, 0, 5'd6, 0, 0));
      drive(mk(0, 0, 5'd5, 1, 1, 0, 5'd6, 0, 0));
      // same load-use with a redirect: bubble only, no count
      drive(mk(0, 0, 0, 0, 1, 1, 5'd5, 0, 0));
      drive(mk(0, 0, 5'd5, 1, 1, 0, 5'd6, 1, 0));
      drive(mk(5'd6, 1, 5'd5, 1, 0, 0, 5'd0, 0, 0));
      // r0 never forwards; r7 in E, M and W gives E priority
      drive(mk(0, 0, 0, 0, 1, 0, 5'd0, 0, 0));
      drive(mk(5'd0, 1, 5'd0, 1, 1, 0, 5'd7, 0, 0));
      drive(mk(0, 0, 0, 0, 1, 0, 5'd7, 0, 0));
      drive(mk(0, 0, 0, 0, 1, 0, 5'd7, 0, 0));
      drive(mk(5'd7, 1, 5'd7, 1, 0, 0, 5'd0, 0, 0));
      // busy execute holding r9 for five edges (saturates the 2-bit counter)
      drive(mk(0, 0, 0, 0, 1, 0, 5'd9, 0, 0));
      for (int i = 0; i < 5; i++) drive(mk(5'd9, 1, 0, 0, 0, 0, 5'd0, i == 2, 1));
      drive(mk(5'd9, 1, 0, 0, 0, 0, 5'd0, 0, 0));
      // reset mid-busy abandons the stall
      drive(mk(0, 0, 0, 0, 1, 1, 5'd4, 0, 0));
      drive(mk(5'd4, 1, 0, 0, 0, 0, 5'd0, 0, 1));
      drive(rst0);
      drive(mk(5'd4, 1, 5'd4, 1, 0, 0, 5'd0, 0, 0));
      // random traffic over a small register set so hazards are frequent
      for (int i = 0; i < 3000; i++) drive(rand_in());
      drive(idle);
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clock);
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
